// File: rtl/spi_slave_shift_if.sv
// rtl/spi_slave_shift_if.sv - parallel word handshake between SPI slave shifter and its host
//
// Purpose: carries the transmit holding-register load path and the
// received-character strobe path of spi_slave_shift.
// Signals:
//   tx_data  [SPI_MAX_CHAR]  host -> slave  parallel transmit word
//   tx_valid                 host -> slave  tx_data is valid
//   tx_ready                 slave -> host  holding register empty
//   rx_data  [SPI_MAX_CHAR]  slave -> host  last received character
//   rx_valid                 slave -> host  one-cycle strobe, rx_data updated
// Modports: slave (the shifter), master (the host side).

interface spi_slave_shift_if #(
  parameter int SPI_MAX_CHAR = 32
);
  logic [SPI_MAX_CHAR-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [SPI_MAX_CHAR-1:0] rx_data;
  logic                    rx_valid;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave_shift.sv
// rtl/spi_slave_shift.sv - SPI slave character shifter with transmit holding register
//
// Purpose: oversampled SPI slave. s_clk, ss_n and s_in are synchronized into
// clk (clk >= 4x s_clk); characters of 2..SPI_MAX_CHAR bits are shifted in on
// the sample edge and out on the drive edge, MSB or LSB first.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   len                   character length minus one (0 = SPI_MAX_CHAR bits)
//   lsb                   LSB first on the line
//   rx_negedge            sample MOSI on falling s_clk
//   tx_negedge            drive MISO on falling s_clk
//   s_clk, ss_n, s_in     serial clock, select (active-low), MOSI; all async
//   s_out, s_oe           MISO and its output enable
//   tip                   frame active
//   underrun              one-cycle strobe: character started with empty holding register
//   frame_err             one-cycle strobe: select released mid-character
//   bus                   tx holding-register load and rx character strobe

module spi_slave_shift #(
  parameter int SPI_MAX_CHAR      = 32,
  parameter int SPI_CHAR_LEN_BITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SPI_CHAR_LEN_BITS-1:0] len,
  input  logic                         lsb,
  input  logic                         rx_negedge,
  input  logic                         tx_negedge,
  input  logic                         s_clk,
  input  logic                         ss_n,
  input  logic                         s_in,
  output logic                         s_out,
  output logic                         s_oe,
  output logic                         tip,
  output logic                         underrun,
  output logic                         frame_err,
  spi_slave_shift_if.slave             bus
);

  localparam int LB = SPI_CHAR_LEN_BITS;
  localparam logic [LB-1:0] MAX_LAST = LB'(SPI_MAX_CHAR - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [1:0] s_clk_sync, ss_n_sync, s_in_sync;
  logic       s_clk_d, ss_n_d;
  logic       s_clk_s, ss_n_s, s_in_s;
  logic       pos_edge, neg_edge, ss_fall;

  logic [SPI_MAX_CHAR-1:0] hold_data, tx_shift, rx_shift, rx_word, load_word;
  logic                    hold_full;
  logic [LB-1:0]           cur_last, new_last, rx_cnt, tx_idx;
  logic [LB-1:0]           rx_pos, tx_pos, first_pos;
  logic                    cur_lsb, adv_pending;
  logic                    sample, drive, rx_done, char_start, frame_abort;

  // Synchronizers reset to the idle bus state (deselected, s_clk low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_clk_sync <= 2'b00;
      ss_n_sync  <= 2'b11;
      s_in_sync  <= 2'b00;
      s_clk_d    <= 1'b0;
      ss_n_d     <= 1'b1;
    end else begin
      s_clk_sync <= {s_clk_sync[0], s_clk};
      ss_n_sync  <= {ss_n_sync[0], ss_n};
      s_in_sync  <= {s_in_sync[0], s_in};
      s_clk_d    <= s_clk_sync[1];
      ss_n_d     <= ss_n_sync[1];
    end
  end

  assign s_clk_s  = s_clk_sync[1];
  assign ss_n_s   = ss_n_sync[1];
  assign s_in_s   = s_in_sync[1];
  assign pos_edge = s_clk_s & ~s_clk_d;
  assign neg_edge = ~s_clk_s & s_clk_d;
  assign ss_fall  = ss_n_d & ~ss_n_s;

  assign sample  = (state == SHIFT) && (rx_negedge ? neg_edge : pos_edge);
  assign drive   = (state == SHIFT) && (tx_negedge ? neg_edge : pos_edge);
  assign rx_done = sample && (rx_cnt == cur_last);

  // Highest bit index of a character: len itself, or the full width when len==0.
  assign new_last  = (len == '0) ? MAX_LAST : len;
  assign first_pos = lsb ? '0 : new_last;
  assign rx_pos    = cur_lsb ? rx_cnt : cur_last - rx_cnt;
  assign tx_pos    = cur_lsb ? tx_idx : cur_last - tx_idx;
  assign load_word = hold_full ? hold_data : '0;

  always_comb begin
    rx_word         = rx_shift;
    rx_word[rx_pos] = s_in_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A completing character outranks a simultaneous select release: the word
  // is delivered, no error is flagged, and no new character is started.
  always_comb begin
    state_nxt   = state;
    char_start  = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt  = SHIFT;
          char_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_n_s) begin
          state_nxt   = IDLE;
          frame_abort = !rx_done && (rx_cnt != '0);
        end else if (rx_done) begin
          char_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data    <= '0;
      hold_full    <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      cur_last     <= MAX_LAST;
      cur_lsb      <= 1'b0;
      rx_cnt       <= '0;
      tx_idx       <= '0;
      adv_pending  <= 1'b0;
      s_out        <= 1'b0;
      underrun     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      underrun     <= 1'b0;
      frame_err    <= frame_abort;

      // Load requires empty, consume requires full: never both in one cycle.
      if (bus.tx_valid && !hold_full) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (rx_done) begin
        bus.rx_data  <= rx_word;
        bus.rx_valid <= 1'b1;
      end

      if (char_start) begin
        cur_last    <= new_last;
        cur_lsb     <= lsb;
        rx_cnt      <= '0;
        rx_shift    <= '0;
        adv_pending <= 1'b0;
        tx_idx      <= LB'(1);
        tx_shift    <= load_word;
        s_out       <= load_word[first_pos];
        if (hold_full) hold_full <= 1'b0;
        else           underrun  <= 1'b1;
      end else if (state_nxt == IDLE) begin
        rx_cnt      <= '0;
        rx_shift    <= '0;
        tx_shift    <= '0;
        adv_pending <= 1'b0;
        s_out       <= 1'b0;
      end else if (sample) begin
        rx_shift    <= rx_word;
        rx_cnt      <= rx_cnt + LB'(1);
        adv_pending <= 1'b1;
      end else if (drive && adv_pending) begin
        // Drive edges before the first sample leave the first bit in place,
        // which is what lets both clock phases share one datapath.
        s_out       <= tx_shift[tx_pos];
        tx_idx      <= tx_idx + LB'(1);
        adv_pending <= 1'b0;
      end
    end
  end

  assign bus.tx_ready = ~hold_full;
  assign tip          = (state == SHIFT);
  assign s_oe         = tip;

endmodule
